cosine_sequencer: RTL

- Control FSM that drives the 3-bit state bus consumed by the cosine/distance datapath.
- Qualifies an external trigger, then steps the datapath through start, term accumulation and distance calculation.
- Captures the datapath's Q5.11 distance when its done flag rises and presents it downstream on a valid/ready handshake.
- Sits between the sensor-trigger logic and the datapath; it is the datapath's sole state source.

---
 rtl/cosine_sequencer_pkg.sv | 19 +
 rtl/cosine_sequencer_cycle.sv | 32 +++
 rtl/cosine_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cosine_sequencer_pkg.sv
// Shared definitions for the cosine/distance sequencer and its datapath.
// Holds the state bus encodings (which the datapath decodes) and the
// Q5.11 fixed-point constants used for distance values.
package cosine_sequencer_pkg;

  typedef enum logic [2:0] {
    StandBy           = 3'd0,
    Alert             = 3'd1,
    StartCalculation  = 3'd2,
    AccumulateTerms   = 3'd3,
    CalculateDistance = 3'd4,
    Capture           = 3'd5
  } seqState_t;

  localparam int          DEFAULT_WIDTH = 16;
  localparam int          FRAC_BITS     = 11;
  localparam logic [15:0] ONE           = 16'h0800;

endpackage

// File: rtl/cosine_sequencer_cycle.sv
// cycle_counter: parameterised up-counter with synchronous clear, count
// enable and a terminal-count compare.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   clear        forces count to 0 (wins over enable)
//   enable       increments count
//   terminal     compare value
//   count        current count
//   atTerminal   count == terminal
module cycle_counter
  import cosine_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] terminal,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 atTerminal
);

  always_ff @(posedge clk) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign atTerminal = (count == terminal);

endmodule

// File: rtl/cosine_sequencer.sv
// cosine_sequencer: control FSM driving the cosine/distance datapath state
// bus. Qualifies a trigger, steps the datapath through start, term
// accumulation and distance calculation, then captures the Q5.11 distance
// and offers it on a valid/ready handshake.
//
// state             | meaning
// StandBy (0)       | idle; waits for trigger while no result is pending
// Alert (1)         | trigger qualification, ALERT_CYCLES consecutive highs
// StartCalculation  | one-cycle datapath start
// AccumulateTerms   | NUM_TERMS cycles, term_idx = 1..NUM_TERMS
// CalculateDistance | one-cycle distance calculation
// Capture (5)       | waits for dp_done, aborts after DONE_TIMEOUT cycles
//
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   trigger            raw request from sensor logic
//   dp_done            datapath done flag
//   dp_distance        datapath distance (Q5.11)
//   state              state bus to datapath
//   term_idx           current term, 0 outside AccumulateTerms
//   busy               state != StandBy
//   result             captured distance
//   result_valid       result available
//   result_ready       downstream accepts result
//   timeout_err        sticky done-timeout flag
module cosine_sequencer
  import cosine_sequencer_pkg::*;
#(
  parameter int NUM_TERMS    = 6,
  parameter int ALERT_CYCLES = 4,
  parameter int DONE_TIMEOUT = 8,
  parameter int WIDTH        = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             dp_done,
  input  logic [WIDTH-1:0] dp_distance,
  output logic [2:0]       state,
  output logic [3:0]       term_idx,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             timeout_err
);

  localparam logic [3:0] ALERT_LAST   = 4'(ALERT_CYCLES - 1);
  localparam logic [3:0] TERM_LAST    = 4'(NUM_TERMS);
  localparam logic [7:0] TIMEOUT_LAST = 8'(DONE_TIMEOUT - 1);

  seqState_t        curState, nextState;
  logic [WIDTH-1:0] resultNext;
  logic             validNext, errNext;

  logic       alertClear, alertEn, alertLast;
  logic       termClear, termEn, termLast;
  logic       toClear, toEn, toLast;
  logic [3:0] alertCount;
  logic [7:0] timeoutCount;
  logic       unusedCounts;

  cycle_counter #(.CNT_WIDTH(4)) u_alertCnt (
    .clk(clk), .rst_n(rst_n), .clear(alertClear), .enable(alertEn),
    .terminal(ALERT_LAST), .count(alertCount), .atTerminal(alertLast)
  );

  // The term counter doubles as term_idx: it is held at 0 everywhere except
  // StartCalculation (which pre-increments to 1) and AccumulateTerms.
  cycle_counter #(.CNT_WIDTH(4)) u_termCnt (
    .clk(clk), .rst_n(rst_n), .clear(termClear), .enable(termEn),
    .terminal(TERM_LAST), .count(term_idx), .atTerminal(termLast)
  );

  cycle_counter #(.CNT_WIDTH(8)) u_timeoutCnt (
    .clk(clk), .rst_n(rst_n), .clear(toClear), .enable(toEn),
    .terminal(TIMEOUT_LAST), .count(timeoutCount), .atTerminal(toLast)
  );

  // Only the terminal compares of the alert and timeout counters matter.
  assign unusedCounts = ^{alertCount, timeoutCount};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      curState     <= StandBy;
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      curState     <= nextState;
      result       <= resultNext;
      result_valid <= validNext;
      timeout_err  <= errNext;
    end
  end

  always_comb begin
    nextState  = curState;
    resultNext = result;
    validNext  = result_valid;
    errNext    = timeout_err;

    alertClear = (curState != Alert);
    alertEn    = (curState == Alert) && trigger;
    termEn     = (curState == StartCalculation) || (curState == AccumulateTerms);
    termClear  = !termEn || ((curState == AccumulateTerms) && termLast);
    toClear    = (curState != Capture);
    toEn       = (curState == Capture) && !dp_done;

    if (result_valid && result_ready) validNext = 1'b0;

    case (curState)
      StandBy:           if (trigger && !result_valid) nextState = Alert;
      Alert: begin
        if (!trigger)       nextState = StandBy;
        else if (alertLast) nextState = StartCalculation;
      end
      StartCalculation:  nextState = AccumulateTerms;
      AccumulateTerms:   if (termLast) nextState = CalculateDistance;
      CalculateDistance: nextState = Capture;
      Capture: begin
        if (dp_done) begin
          resultNext = dp_distance;
          validNext  = 1'b1;
          nextState  = StandBy;
        end else if (toLast) begin
          errNext   = 1'b1;
          nextState = StandBy;
        end
      end
      default:           nextState = StandBy;
    endcase
  end

  assign state = curState;
  assign busy  = (curState != StandBy);

endmodule
